// File: rtl/alu_share_arb.sv
// Two-port arbiter sharing one combinational ALU, with a one-deep response slot per requester.
// Build option: define ALU_SHARE_ARB_RR_EN for round-robin contests (default build is fixed priority, req0 wins).
module alu_share_arb #(
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [SEL_W-1:0]  req0_sel,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [SEL_W-1:0]  req1_sel,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [SEL_W-1:0]  alu_sel,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [DATA_W-1:0] alu_out,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic [DATA_W-1:0] rsp0_data,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [DATA_W-1:0] rsp1_data,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic              elig0_s;
  logic              elig1_s;
  logic              contest_s;
  logic              grant0_s;
  logic              grant1_s;
  logic [SEL_W-1:0]  alu_sel_s;
  logic [DATA_W-1:0] alu_a_s;
  logic [DATA_W-1:0] alu_b_s;

  logic              rsp0_valid_r;
  logic              rsp1_valid_r;
  logic [DATA_W-1:0] rsp0_data_r;
  logic [DATA_W-1:0] rsp1_data_r;
  logic [CNT_W-1:0]  conflict_cnt_r;
`ifdef ALU_SHARE_ARB_RR_EN
  logic              last_r;
`endif

  // Eligibility and grant selection; a full slot being drained this cycle may refill.
  always_comb begin
    elig0_s   = req0_valid && (!rsp0_valid_r || rsp0_ready);
    elig1_s   = req1_valid && (!rsp1_valid_r || rsp1_ready);
    contest_s = elig0_s && elig1_s;
    grant0_s  = 1'b0;
    grant1_s  = 1'b0;
    if (contest_s) begin
`ifdef ALU_SHARE_ARB_RR_EN
      // winner is !last, so last=1 hands the contest to req0
      grant0_s = last_r;
`else
      grant0_s = 1'b1;
`endif
      grant1_s = !grant0_s;
    end else begin
      grant0_s = elig0_s;
      grant1_s = elig1_s;
    end
  end

  // Shared ALU operand mux; idle cycles present ADD 0+0.
  always_comb begin
    alu_sel_s = {SEL_W{1'b0}};
    alu_a_s   = {DATA_W{1'b0}};
    alu_b_s   = {DATA_W{1'b0}};
    case ({grant1_s, grant0_s})
      2'b01: begin
        alu_sel_s = req0_sel;
        alu_a_s   = req0_a;
        alu_b_s   = req0_b;
      end
      2'b10: begin
        alu_sel_s = req1_sel;
        alu_a_s   = req1_a;
        alu_b_s   = req1_b;
      end
      default: begin
        alu_sel_s = {SEL_W{1'b0}};
        alu_a_s   = {DATA_W{1'b0}};
        alu_b_s   = {DATA_W{1'b0}};
      end
    endcase
  end

  // Requester 0 response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp0_valid_r <= 1'b0;
      rsp0_data_r  <= {DATA_W{1'b0}};
    end else if (grant0_s) begin
      rsp0_valid_r <= 1'b1;
      rsp0_data_r  <= alu_out;
    end else if (rsp0_valid_r && rsp0_ready) begin
      rsp0_valid_r <= 1'b0;
    end else begin
      rsp0_valid_r <= rsp0_valid_r;
    end
  end

  // Requester 1 response slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp1_valid_r <= 1'b0;
      rsp1_data_r  <= {DATA_W{1'b0}};
    end else if (grant1_s) begin
      rsp1_valid_r <= 1'b1;
      rsp1_data_r  <= alu_out;
    end else if (rsp1_valid_r && rsp1_ready) begin
      rsp1_valid_r <= 1'b0;
    end else begin
      rsp1_valid_r <= rsp1_valid_r;
    end
  end

  // Saturating count of two-way contests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict_cnt_r <= {CNT_W{1'b0}};
    end else if (contest_s && (conflict_cnt_r != {CNT_W{1'b1}})) begin
      conflict_cnt_r <= conflict_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      conflict_cnt_r <= conflict_cnt_r;
    end
  end

`ifdef ALU_SHARE_ARB_RR_EN
  // Round-robin pointer remembers the winner of the latest contest only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_r <= 1'b1;
    end else if (contest_s) begin
      last_r <= grant1_s;
    end else begin
      last_r <= last_r;
    end
  end
`endif

  assign req0_ready   = grant0_s;
  assign req1_ready   = grant1_s;
  assign alu_sel      = alu_sel_s;
  assign alu_a        = alu_a_s;
  assign alu_b        = alu_b_s;
  assign rsp0_valid   = rsp0_valid_r;
  assign rsp1_valid   = rsp1_valid_r;
  assign rsp0_data    = rsp0_data_r;
  assign rsp1_data    = rsp1_data_r;
  assign conflict_cnt = conflict_cnt_r;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb with a behavioural ALU and per-requester result queues.
module tb_alu_share_arb;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_sel, req1_sel;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0]  alu_sel;
  logic [31:0] alu_a, alu_b, alu_out;
  logic        rsp0_valid, rsp1_valid;
  logic        rsp0_ready, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [15:0] conflict_cnt;

  int checks;
  int failures;
  logic [31:0] q0[$];
  logic [31:0] q1[$];
  logic [31:0] exp_d;

  function automatic logic [31:0] ref_alu(input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    case (s)
      4'h0:    return a + b;
      4'h8:    return a - b;
      4'h7:    return a & b;
      4'h6:    return a | b;
      4'h4:    return a ^ b;
      default: return a + b;
    endcase
  endfunction

  assign alu_out = ref_alu(alu_sel, alu_a, alu_b);

  alu_share_arb #(.DATA_W(32), .SEL_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_sel(req0_sel), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_sel(req1_sel), .req1_a(req1_a), .req1_b(req1_b),
    .alu_sel(alu_sel), .alu_a(alu_a), .alu_b(alu_b), .alu_out(alu_out),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready), .rsp0_data(rsp0_data),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready), .rsp1_data(rsp1_data),
    .conflict_cnt(conflict_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_req0(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req0_valid = v; req0_sel = s; req0_a = a; req0_b = b;
  endtask

  task automatic set_req1(input logic v, input logic [3:0] s, input logic [31:0] a, input logic [31:0] b);
    req1_valid = v; req1_sel = s; req1_a = a; req1_b = b;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    #2;
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b%0b exp=00", rsp0_valid, rsp1_valid); end
    checks++; if (rsp0_data !== 32'h0 || rsp1_data !== 32'h0) begin failures++; $display("FAIL reset_data got=%h/%h exp=0", rsp0_data, rsp1_data); end
    checks++; if (conflict_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", conflict_cnt); end
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || alu_sel !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin
      failures++; $display("FAIL reset_comb got ready=%0b%0b alu=%h/%h/%h exp=0", req0_ready, req1_ready, alu_sel, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    rsp0_ready = 1'b1;
    set_req0(1'b1, 4'h0, 32'd5, 32'd7);
    #1;
    checks++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin failures++; $display("FAIL single_grant got=%0b%0b exp=01", req1_ready, req0_ready); end
    checks++; if (alu_sel !== 4'h0 || alu_a !== 32'd5 || alu_b !== 32'd7) begin failures++; $display("FAIL single_alu got=%h/%h/%h exp=0/5/7", alu_sel, alu_a, alu_b); end
    q0.push_back(32'd12);
    tick();
    set_req0(1'b0, 4'h0, 32'd0, 32'd0);
    checks++; if (rsp0_valid !== 1'b1) begin failures++; $display("FAIL single_valid got=%0b exp=1", rsp0_valid); end
    checks++;
    if (q0.size() == 0) begin failures++; $display("FAIL single_data got=%h exp=<none queued>", rsp0_data); end
    else begin exp_d = q0.pop_front(); if (rsp0_data !== exp_d) begin failures++; $display("FAIL single_data got=%h exp=%h", rsp0_data, exp_d); end end
    #1;
    checks++; if (alu_sel !== 4'h0 || alu_a !== 32'h0 || alu_b !== 32'h0) begin failures++; $display("FAIL idle_alu got=%h/%h/%h exp=0", alu_sel, alu_a, alu_b); end
    tick();
    checks++; if (rsp0_valid !== 1'b0) begin failures++; $display("FAIL single_drain got=%0b exp=0", rsp0_valid); end
  endtask

  task automatic test_contest();
    logic exp_g1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_req0(1'b1, (i % 2 == 0) ? 4'h0 : 4'h8, 32'd100 + i, 32'(i));
      set_req1(1'b1, 4'h7, 32'hF0F0_0000 + 32'(50 * i), 32'hFFFF_00FF);
`ifdef ALU_SHARE_ARB_RR_EN
      exp_g1 = (i % 2) == 1;
`else
      exp_g1 = 1'b0;
`endif
      #1;
      checks++; if (req0_ready !== !exp_g1 || req1_ready !== exp_g1) begin
        failures++; $display("FAIL contest_grant[%0d] got r1r0=%0b%0b exp=%0b%0b", i, req1_ready, req0_ready, exp_g1, !exp_g1);
      end
      if (exp_g1) q1.push_back(ref_alu(req1_sel, req1_a, req1_b));
      else        q0.push_back(ref_alu(req0_sel, req0_a, req0_b));
      tick();
      checks++;
      if (exp_g1) begin
        if (q1.size() == 0) begin failures++; $display("FAIL contest_data1 got=%h exp=<none queued>", rsp1_data); end
        else begin exp_d = q1.pop_front(); if (rsp1_valid !== 1'b1 || rsp1_data !== exp_d) begin failures++; $display("FAIL contest_data1[%0d] got v=%0b d=%h exp v=1 d=%h", i, rsp1_valid, rsp1_data, exp_d); end end
      end else begin
        if (q0.size() == 0) begin failures++; $display("FAIL contest_data0 got=%h exp=<none queued>", rsp0_data); end
        else begin exp_d = q0.pop_front(); if (rsp0_valid !== 1'b1 || rsp0_data !== exp_d) begin failures++; $display("FAIL contest_data0[%0d] got v=%0b d=%h exp v=1 d=%h", i, rsp0_valid, rsp0_data, exp_d); end end
      end
    end
    checks++; if (conflict_cnt !== 16'd4) begin failures++; $display("FAIL contest_cnt got=%0d exp=4", conflict_cnt); end
    set_req0(1'b0, 4'h0, 32'h0, 32'h0);
    set_req1(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
    checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin failures++; $display("FAIL contest_drain got=%0b%0b exp=00", rsp1_valid, rsp0_valid); end
  endtask

  task automatic test_backpressure();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b0;
    set_req0(1'b1, 4'h0, 32'd4, 32'd6);
    tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000_000A) begin failures++; $display("FAIL bp_first got v=%0b d=%h exp v=1 d=0000000a", rsp0_valid, rsp0_data); end
    rsp0_ready = 1'b0;
    set_req0(1'b1, 4'h0, 32'd1, 32'd1);
    set_req1(1'b1, 4'h8, 32'd3, 32'd5);
    #1;
    checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin failures++; $display("FAIL bp_grant got r1r0=%0b%0b exp=10", req1_ready, req0_ready); end
    tick();
    set_req1(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rsp1_valid !== 1'b1 || rsp1_data !== 32'hFFFF_FFFE) begin failures++; $display("FAIL bp_rsp1 got v=%0b d=%h exp v=1 d=fffffffe", rsp1_valid, rsp1_data); end
    checks++; if (rsp0_data !== 32'h0000_000A) begin failures++; $display("FAIL bp_hold got=%h exp=0000000a", rsp0_data); end
    checks++; if (conflict_cnt !== 16'd4) begin failures++; $display("FAIL bp_cnt got=%0d exp=4", conflict_cnt); end
    #1;
    checks++; if (req0_ready !== 1'b0) begin failures++; $display("FAIL bp_blocked got=%0b exp=0", req0_ready); end
    tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'h0000_000A) begin failures++; $display("FAIL bp_hold2 got v=%0b d=%h exp v=1 d=0000000a", rsp0_valid, rsp0_data); end
    rsp0_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL bp_release got=%0b exp=1", req0_ready); end
    tick();
    checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd2) begin failures++; $display("FAIL bp_refill got v=%0b d=%h exp v=1 d=2", rsp0_valid, rsp0_data); end
    set_req0(1'b0, 4'h0, 32'h0, 32'h0);
    rsp1_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [3:0] sels [5];
    sels = '{4'h0, 4'h8, 4'h7, 4'h6, 4'h4};
    rsp0_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_req0(1'b1, sels[i], 32'h1234_0000 + 32'(i * 17), 32'h0000_FF0F + 32'(i));
      #1;
      checks++; if (req0_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, req0_ready); end
      q0.push_back(ref_alu(req0_sel, req0_a, req0_b));
      tick();
      checks++;
      if (q0.size() == 0) begin failures++; $display("FAIL b2b_data got=%h exp=<none queued>", rsp0_data); end
      else begin exp_d = q0.pop_front(); if (rsp0_valid !== 1'b1 || rsp0_data !== exp_d) begin failures++; $display("FAIL b2b_data[%0d] got v=%0b d=%h exp v=1 d=%h", i, rsp0_valid, rsp0_data, exp_d); end end
    end
    set_req0(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_saturation();
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    set_req0(1'b1, 4'h0, 32'd1, 32'd2);
    set_req1(1'b1, 4'h0, 32'd3, 32'd4);
    for (int i = 0; i < 65539; i++) tick();
    checks++; if (conflict_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_cnt got=%h exp=ffff", conflict_cnt); end
    set_req0(1'b0, 4'h0, 32'h0, 32'h0);
    set_req1(1'b0, 4'h0, 32'h0, 32'h0);
    tick();
  endtask

  task automatic test_midrun_reset();
    rsp0_ready = 1'b0;
    set_req0(1'b1, 4'h0, 32'd9, 32'd0);
    tick();
    set_req0(1'b0, 4'h0, 32'h0, 32'h0);
    checks++; if (rsp0_valid !== 1'b1 || rsp0_data !== 32'd9) begin failures++; $display("FAIL mr_pre got v=%0b d=%h exp v=1 d=9", rsp0_valid, rsp0_data); end
    rst_n = 1'b0;
    #1;
    checks++; if (rsp0_valid !== 1'b0 || rsp0_data !== 32'h0 || conflict_cnt !== 16'h0) begin
      failures++; $display("FAIL mr_async got v=%0b d=%h cnt=%h exp 0/0/0", rsp0_valid, rsp0_data, conflict_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    rsp0_ready = 1'b0;
    rsp1_ready = 1'b0;
    set_req0(1'b0, 4'h0, 32'h0, 32'h0);
    set_req1(1'b0, 4'h0, 32'h0, 32'h0);
    test_reset();
    test_single();
    test_contest();
    test_backpressure();
    test_back_to_back();
    test_saturation();
    test_midrun_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_share_arb.md
# alu_share_arb

Two-port arbiter that time-shares one combinational integer ALU between two requesters, e.g. the execute stage and a branch/address-generation helper. Each requester issues operations over a valid/ready handshake. The arbiter grants at most one per cycle, drives the ALU with the winner's operands, and captures the ALU result into that requester's one-deep response register. The response is presented back over a second valid/ready handshake.

## Interface
- `DATA_W`, 32, operand/result width
- `SEL_W`, 4, ALU select width; passed through unmodified
- `CNT_W`, 16, width of the conflict counter
---
- `clk`  in  1  clock, all state on rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req0_valid` / `req1_valid`  in  1  operation request
- `req0_ready` / `req1_ready`  out  1  request accepted this cycle (grant)
- `req0_sel` / `req1_sel`  in  SEL_W  ALU select code
- `req0_a`, `req0_b` / `req1_a`, `req1_b`  in  DATA_W  operands
- `alu_sel`  out  SEL_W  to shared ALU
- `alu_a`, `alu_b`  out  DATA_W  to shared ALU
- `alu_out`  in  DATA_W  combinational result from shared ALU
- `rsp0_valid` / `rsp1_valid`  out  1  result held
- `rsp0_ready` / `rsp1_ready`  in  1  requester consumes result
- `rsp0_data` / `rsp1_data`  out  DATA_W  result
- `conflict_cnt`  out  CNT_W  saturating count of lost-arbitration cycles

## Operation
- **Eligibility:** requester k is eligible when `reqk_valid` is high and either `rspk_valid` is low or `rspk_ready` is high (the slot is drained and refilled in the same cycle).
- **Grant:**
  - Only one requester eligible: it is granted.
  - Both eligible: the policy decides (see Configuration).
  - `reqk_ready` is high exactly when k is granted.
  - Each grant is a pure function of the current-cycle inputs and state.
- **Requester rule:** requesters must not make `reqk_valid` depend on `reqk_ready`, and must hold `sel`/`a`/`b` stable while valid is high and ready is low.
- **ALU drive:**
  - With a grant, `alu_sel`/`alu_a`/`alu_b` are the winner's fields.
  - Without a grant, all three are driven to 0; 0 is ADD, so the ALU sees 0+0.
- **Capture:**
  - On a granted edge, `rspk_data` <= `alu_out` and `rspk_valid` <= 1.
  - If `rspk_valid && rspk_ready` with no new grant, `rspk_valid` <= 0.
  - `rspk_data` holds its value while valid and not consumed.
- **Response order:** responses per requester stay in issue order, which follows trivially from the one-deep slot.
- **Round-robin pointer:**
  - `last` is 1 bit, holding the index of the most recent winner of a two-way contest.
  - `last` updates only when both requesters were eligible.
- **Conflict counter:**
  - Increments by 1 on every cycle where both requesters were eligible.
  - Saturates at all-ones and does not wrap.
- **Datapath width:** no arithmetic in the block apart from the counter increment.

## Timing
- **Request-to-response latency:** one cycle. A request accepted at edge N shows `rspk_valid`=1 and the data after edge N, so it is visible in cycle N+1.
- **Throughput:**
  - One operation per cycle in total.
  - One per cycle per requester when its response is consumed every cycle.
- **Combinational paths:**
  - `reqk_ready` depends on both `req*_valid`, on `rspk_ready`, and on state.
  - `alu_*` outputs depend on the same signals.
- **Reset values:**
  - `rsp0_valid`=`rsp1_valid`=0 and `rsp0_data`=`rsp1_data`=0.
  - `conflict_cnt`=0 and `last`=1, so req0 wins the first contest.
  - `req*_ready` and `alu_*` follow the combinational rules: with inputs low they are 0.
- **Reset mid-operation:** held responses are discarded immediately on `rst_n` falling, without waiting for a clock edge.
- **Simultaneous drain and refill:** when `rspk_valid`, `rspk_ready` and a grant to k all coincide, the slot is overwritten with new data and valid stays 1. There is no bubble.
- **Blocked requester:** when `rspk_valid`=1 and `rspk_ready`=0, requester k is ineligible and the other requester is granted freely. This does not count as a conflict.

## Configuration
- `ALU_SHARE_ARB_RR_EN` selects the two-way contest policy; only the contest policy differs between the two builds.
- **Defined:** round-robin; the winner is `!last`, then `last` is updated.
- **Undefined:**
  - Fixed priority: req0 always wins.
  - The `last` register is not built.
  - `conflict_cnt` still counts.

## Test plan
- **Reset:** assert `rst_n`=0 mid-run with `rsp0_valid`=1 -> all rsp valids 0, data 0, `conflict_cnt`=0 with no clock edge needed.
- **Single requester:** req0 sel=0000, a=5, b=7, `rsp0_ready`=1 -> `req0_ready`=1; next cycle `rsp0_valid`=1 and `rsp0_data`=12. With no request, `alu_*` are 0.
- **Round-robin contest (`ALU_SHARE_ARB_RR_EN` defined):** both requesters valid for 4 cycles, both `rsp_ready`=1 -> grants 0,1,0,1 and `conflict_cnt`=4.
- **Fixed-priority contest (macro undefined):** same stimulus as the round-robin contest -> req0 granted all 4 cycles, `req1_ready` stays 0, `conflict_cnt`=4.
- **Backpressure:**
  - Hold `rsp0_ready`=0 after a req0 result of 0xA -> `rsp0_data` stays 0xA, `req0_ready`=0.
  - Meanwhile req1 issues sel=1000, a=3, b=5 -> `rsp1_data`=0xFFFFFFFE, no conflict counted.
- **Drain plus refill and saturation:**
  - Issue back-to-back req0 with `rsp0_ready`=1 -> `rsp0_valid` stays 1 every cycle and the data updates each cycle.
  - Force contention for 2^CNT_W+3 cycles -> `conflict_cnt`=0xFFFF.
